// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the two-requester SD sector arbiter.
package sd_arb_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DONE
  } arb_state_t;

  // Round-robin pick: on a tie the requester that was not served last wins.
  function automatic logic pick_winner(input logic [NREQ-1:0] pend, input logic last_grant);
    if (&pend) return ~last_grant;
    return pend[1];
  endfunction

endpackage

// File: rtl/sd_arb_timeout.sv
// Loadable saturating up-counter that flags when it reaches LIMIT-1.
module sd_arb_timeout #(
  parameter int LIMIT = 21477000,
  parameter int W     = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         terminal
);

  localparam logic [W-1:0] TERM = W'(LIMIT - 1);

  logic [W-1:0] count;

  assign terminal = (count >= TERM);

  // Holds at the terminal value instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares one mist_io sector port between two requesters with round-robin
// arbitration, an ack timeout and XFER-only buffer routing.
module sd_sector_arbiter
  import sd_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 21477000,
  parameter int TMO_W          = 25
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [NREQ-1:0][31:0] rq_lba,
  input  logic [NREQ-1:0]       rq_rd,
  input  logic [NREQ-1:0]       rq_wr,
  output logic [NREQ-1:0]       rq_done,
  output logic [NREQ-1:0]       rq_err,
  input  logic [NREQ-1:0][7:0]  rq_buff_din,
  output logic [8:0]            rq_buff_addr,
  output logic [7:0]            rq_buff_dout,
  output logic [NREQ-1:0]       rq_buff_wr,
  output logic [31:0]           sd_lba,
  output logic                  sd_rd,
  output logic                  sd_wr,
  input  logic                  sd_ack,
  input  logic [8:0]            sd_buff_addr,
  input  logic [7:0]            sd_buff_dout,
  input  logic                  sd_buff_wr,
  output logic [7:0]            sd_buff_din,
  output logic                  busy,
  output logic                  grant
);

  arb_state_t      state, next_state;
  logic [NREQ-1:0] pend;
  logic            winner;
  logic            last_grant;
  logic            op_wr;
  logic            tmo_load, tmo_en, tmo_term;
  logic            timed_out;

  assign pend = rq_rd | rq_wr;

  sd_arb_timeout #(
    .LIMIT(TIMEOUT_CYCLES),
    .W    (TMO_W)
  ) u_timeout (
    .clk     (clk_sys),
    .reset   (reset),
    .load    (tmo_load),
    .load_val('0),
    .en      (tmo_en),
    .terminal(tmo_term)
  );

  // An ack in the same cycle as a cancel or timeout wins: mist_io has started.
  always_comb begin
    next_state = state;
    winner     = pick_winner(pend, last_grant);
    tmo_load   = 1'b0;
    tmo_en     = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) begin
          next_state = REQ;
          tmo_load   = 1'b1;
        end
      end
      REQ: begin
        tmo_en = 1'b1;
        if (sd_ack) begin
          next_state = XFER;
        end else if (!pend[grant]) begin
          next_state = IDLE;
        end else if (tmo_term) begin
          next_state = IDLE;
          timed_out  = 1'b1;
        end
      end
      XFER: begin
        if (!sd_ack) next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      op_wr      <= 1'b0;
      sd_lba     <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      rq_done    <= '0;
      rq_err     <= '0;
      busy       <= 1'b0;
    end else begin
      state   <= next_state;
      busy    <= (next_state != IDLE);
      rq_done <= '0;
      rq_err  <= '0;
      if (state == IDLE && next_state == REQ) begin
        grant  <= winner;
        sd_lba <= rq_lba[winner];
        op_wr  <= ~rq_rd[winner];
      end
      sd_rd <= (state == REQ) && (next_state == REQ) && !op_wr;
      sd_wr <= (state == REQ) && (next_state == REQ) && op_wr;
      if (timed_out) rq_err[grant] <= 1'b1;
      if (next_state == DONE) rq_done[grant] <= 1'b1;
      if (state == DONE) last_grant <= grant;
    end
  end

  always_comb begin
    rq_buff_wr   = '0;
    rq_buff_addr = '0;
    rq_buff_dout = '0;
    sd_buff_din  = '0;
    if (state == XFER) begin
      rq_buff_wr[grant] = sd_buff_wr;
      rq_buff_addr      = sd_buff_addr;
      rq_buff_dout      = sd_buff_dout;
      sd_buff_din       = rq_buff_din[grant];
    end
  end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Self-checking bench: vector table, directed corner cases and a randomized
// round-robin run against a transaction-level arbitration model.
module tb_sd_sector_arbiter;

  localparam int TMO = 100;

  logic             clk_sys = 1'b0;
  logic             reset;
  logic [1:0][31:0] rq_lba;
  logic [1:0]       rq_rd, rq_wr, rq_done, rq_err, rq_buff_wr;
  logic [1:0][7:0]  rq_buff_din;
  logic [8:0]       rq_buff_addr, sd_buff_addr;
  logic [7:0]       rq_buff_dout, sd_buff_dout, sd_buff_din;
  logic [31:0]      sd_lba;
  logic             sd_rd, sd_wr, sd_ack, sd_buff_wr, busy, grant;

  int checks = 0;
  int passed = 0;

  logic [1:0] m_pend;
  logic       m_last;
  int         m_kind[2];

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [31:0] lba0;
    logic [31:0] lba1;
    logic        eg;
    logic        ewr;
    logic [31:0] elba;
  } vec_t;

  vec_t vecs[8];

  sd_sector_arbiter #(.TIMEOUT_CYCLES(TMO), .TMO_W(8)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .rq_lba      (rq_lba),
    .rq_rd       (rq_rd),
    .rq_wr       (rq_wr),
    .rq_done     (rq_done),
    .rq_err      (rq_err),
    .rq_buff_din (rq_buff_din),
    .rq_buff_addr(rq_buff_addr),
    .rq_buff_dout(rq_buff_dout),
    .rq_buff_wr  (rq_buff_wr),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr  (sd_buff_wr),
    .sd_buff_din (sd_buff_din),
    .busy        (busy),
    .grant       (grant)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk_sys);
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    rq_rd        = '0;
    rq_wr        = '0;
    rq_lba       = '0;
    rq_buff_din  = '0;
    sd_ack       = 1'b0;
    sd_buff_wr   = 1'b0;
    sd_buff_addr = '0;
    sd_buff_dout = '0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_sd_req"}, {sd_rd, sd_wr}, 2'b00);
    check_output({tag, "_sd_lba"}, sd_lba, 32'h0);
    check_output({tag, "_done_err"}, {rq_done, rq_err}, 4'b0000);
    check_output({tag, "_busy_grant"}, {busy, grant}, 2'b00);
    check_output({tag, "_buff_wr"}, rq_buff_wr, 2'b00);
  endtask

  // Plays the mist_io side of one transaction and checks the arbiter around it.
  task automatic serve(input logic eg, input logic ewr, input logic [31:0] elba, input int nstb,
                       input int dly, input int exp_lat, input bit drop_all);
    int         t;
    logic [7:0] d;
    logic [1:0] onehot;
    onehot = eg ? 2'b10 : 2'b01;
    t = 0;
    while (!(sd_rd || sd_wr) && t < 20) begin
      cyc();
      t++;
    end
    if (t >= 20) begin
      check_output("sd_req_wait", 0, 1);
      rq_rd = '0;
      rq_wr = '0;
      return;
    end
    if (exp_lat >= 0) check_output("req_latency", t, exp_lat);
    check_output("grant", grant, eg);
    check_output("sd_rd_wr", {sd_rd, sd_wr}, {~ewr, ewr});
    check_output("sd_lba", sd_lba, elba);
    repeat (dly) cyc();
    sd_ack = 1'b1;
    cyc();
    check_output("sd_req_drop_xfer", {sd_rd, sd_wr, busy}, 3'b001);
    for (int i = 0; i < nstb; i++) begin
      sd_buff_wr   = 1'b1;
      sd_buff_addr = 9'(i);
      d            = 8'($urandom);
      sd_buff_dout = d;
      #1;
      check_output("buff_route", {rq_buff_wr, rq_buff_addr, rq_buff_dout, sd_buff_din},
                   {onehot, 9'(i), d, rq_buff_din[eg]});
      cyc();
    end
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
    cyc();
    check_output("done_pulse", {rq_done, rq_err}, {onehot, 2'b00});
    if (drop_all) begin
      rq_rd = '0;
      rq_wr = '0;
    end else begin
      rq_rd[eg] = 1'b0;
      rq_wr[eg] = 1'b0;
    end
    cyc();
    check_output("done_one_cycle", {rq_done, busy, rq_buff_wr}, 5'b0);
  endtask

  task automatic raise(input int r);
    m_kind[r]      = int'($urandom_range(0, 2));
    rq_rd[r]       = (m_kind[r] != 1);
    rq_wr[r]       = (m_kind[r] != 0);
    rq_lba[r]      = $urandom;
    rq_buff_din[r] = 8'($urandom);
    m_pend[r]      = 1'b1;
  endtask

  initial begin
    int   err_at;
    logic rd_held;
    logic w;

    vecs[0] = '{2'b01, 2'b00, 32'h0000_0123, 32'h0,         1'b0, 1'b0, 32'h0000_0123};
    vecs[1] = '{2'b00, 2'b10, 32'h0,         32'h0000_ABCD, 1'b1, 1'b1, 32'h0000_ABCD};
    vecs[2] = '{2'b01, 2'b10, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0010};
    vecs[3] = '{2'b10, 2'b01, 32'h0000_0030, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0040};
    vecs[4] = '{2'b01, 2'b01, 32'h1234_5678, 32'h0,         1'b0, 1'b0, 32'h1234_5678};
    vecs[5] = '{2'b11, 2'b11, 32'h0000_0050, 32'h0000_0060, 1'b1, 1'b0, 32'h0000_0060};
    vecs[6] = '{2'b00, 2'b01, 32'hCAFE_0001, 32'h0,         1'b0, 1'b1, 32'hCAFE_0001};
    vecs[7] = '{2'b00, 2'b11, 32'h0000_0070, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080};

    do_reset();
    check_reset_values("reset");

    // Single 512-byte read from requester 0.
    rq_lba[0]      = 32'h0000_0123;
    rq_buff_din[0] = 8'h3C;
    rq_buff_din[1] = 8'hC3;
    rq_rd[0]       = 1'b1;
    serve(1'b0, 1'b0, 32'h0000_0123, 512, 5, 2, 1'b1);

    for (int v = 0; v < 8; v++) begin
      rq_lba[0]      = vecs[v].lba0;
      rq_lba[1]      = vecs[v].lba1;
      rq_buff_din[0] = 8'h10 + 8'(v);
      rq_buff_din[1] = 8'h90 + 8'(v);
      rq_rd          = vecs[v].rd;
      rq_wr          = vecs[v].wr;
      serve(vecs[v].eg, vecs[v].ewr, vecs[v].elba, 4, 1, 2, 1'b1);
    end

    // Ack timeout on requester 1.
    do_reset();
    rq_lba[1] = 32'h0000_0BAD;
    rq_rd[1]  = 1'b1;
    cyc();
    err_at  = -1;
    rd_held = 1'b1;
    for (int k = 1; k <= 105; k++) begin
      cyc();
      if (err_at < 0 && rq_err != 2'b00) begin
        err_at = k;
        check_output("tmo_err_pulse", {rq_err, rq_done}, 4'b1000);
        check_output("tmo_sd_rd_drop", {sd_rd, busy}, 2'b00);
        rq_rd[1] = 1'b0;
      end else if (err_at < 0 && !sd_rd) begin
        rd_held = 1'b0;
      end
    end
    check_output("tmo_cycle", err_at, TMO);
    check_output("tmo_sd_rd_held", rd_held, 1'b1);
    check_output("tmo_idle_after", {busy, sd_rd, rq_err}, 4'b0);

    // Requester 1 cancels three cycles into REQ.
    do_reset();
    rq_lba[1] = 32'h0000_0777;
    rq_rd[1]  = 1'b1;
    cyc();
    cyc();
    check_output("cancel_sd_rd_up", {sd_rd, grant}, 2'b11);
    cyc();
    cyc();
    rq_rd[1] = 1'b0;
    cyc();
    check_output("cancel_drop", {sd_rd, sd_wr, busy, rq_done, rq_err}, 7'b0);
    cyc();
    check_output("cancel_quiet", {busy, rq_done, rq_err}, 5'b0);

    // Reset in the middle of a write transfer, then re-arbitration.
    do_reset();
    rq_lba[0] = 32'h0000_0055;
    rq_rd[0]  = 1'b1;
    serve(1'b0, 1'b0, 32'h0000_0055, 4, 2, 2, 1'b1);
    rq_lba[1]      = 32'hDEAD_BEEF;
    rq_buff_din[1] = 8'hA5;
    rq_wr[1]       = 1'b1;
    repeat (3) cyc();
    check_output("rstx_sd_wr", {sd_wr, grant}, 2'b11);
    sd_ack = 1'b1;
    cyc();
    for (int i = 0; i <= 200; i++) begin
      sd_buff_wr   = 1'b1;
      sd_buff_addr = 9'(i);
      if (i < 200) cyc();
    end
    #1;
    check_output("rstx_route_b200", {rq_buff_wr, sd_buff_din}, {2'b10, 8'hA5});
    reset = 1'b1;
    cyc();
    check_reset_values("rstx");
    check_output("rstx_buff_muxes", {rq_buff_addr, rq_buff_dout, sd_buff_din}, 25'b0);
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    cyc();
    check_output("rstx_no_done", {rq_done, rq_err}, 4'b0);
    reset     = 1'b0;
    rq_lba[0] = 32'h0000_0077;
    rq_rd[0]  = 1'b1;
    serve(1'b0, 1'b0, 32'h0000_0077, 3, 1, 2, 1'b0);
    serve(1'b1, 1'b1, 32'hDEAD_BEEF, 3, 1, -1, 1'b0);

    // Randomized traffic against the round-robin model.
    do_reset();
    m_pend = 2'b00;
    m_last = 1'b1;
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!m_pend[r] && ($urandom_range(0, 1) == 1)) raise(r);
      end
      if (m_pend == 2'b00) raise(int'($urandom_range(0, 1)));
      if (m_pend == 2'b11) w = ~m_last;
      else w = (m_pend == 2'b10);
      serve(w, (m_kind[w] == 1), rq_lba[w], int'($urandom_range(1, 16)),
            int'($urandom_range(0, 6)), -1, 1'b0);
      m_last    = w;
      m_pend[w] = 1'b0;
    end

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
